// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains one after another, waiting for each
// domain's ready before the next release; flags timeouts and ready drops.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                             clk,
    input  logic                             in_reset,
    input  logic                             sw_reset_req,
    input  logic [NUM_STAGES-1:0]            stage_ready,
    output logic [NUM_STAGES-1:0]            stage_reset,
    output logic                             all_ready,
    output logic                             timeout_err,
    output logic [clog2w(NUM_STAGES)-1:0]    fail_stage
);

    localparam int unsigned IDX_W   = clog2w(NUM_STAGES);
    localparam int unsigned CNT_MAX = (TIMEOUT > STAGE_DELAY) ? TIMEOUT : STAGE_DELAY;
    localparam int unsigned CNT_W   = clog2w(CNT_MAX);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_reset_q, stage_reset_d;
    logic                    all_ready_q, all_ready_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [IDX_W-1:0]        fail_stage_q, fail_stage_d;

    logic [IDX_W-1:0]        drop_idx;
    logic                    delay_end;
    logic                    wait_end;
    logic                    last_stage;

    // Lowest-numbered stage whose ready has dropped.
    always_comb begin
        drop_idx = '0;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            if (!stage_ready[i]) begin
                drop_idx = IDX_W'(i);
            end
        end
    end

    assign delay_end  = (cnt_q == CNT_W'(STAGE_DELAY - 1));
    assign wait_end   = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        stage_reset_d = stage_reset_q;
        all_ready_d   = all_ready_q;
        timeout_err_d = timeout_err_q;
        fail_stage_d  = fail_stage_q;

        if (sw_reset_req) begin
            state_d       = ST_HOLD;
            cnt_d         = '0;
            idx_d         = '0;
            stage_reset_d = '1;
            all_ready_d   = 1'b0;
            timeout_err_d = 1'b0;
            fail_stage_d  = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    stage_reset_d = '1;
                    if (delay_end) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    stage_reset_d[idx_q] = 1'b0;
                    state_d              = ST_WAIT;
                    cnt_d                = '0;
                end
                ST_WAIT: begin
                    // Ready wins over a timeout landing on the same cycle.
                    if (stage_ready[idx_q]) begin
                        cnt_d = '0;
                        if (last_stage) begin
                            state_d     = ST_DONE;
                            all_ready_d = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end else if (wait_end) begin
                        state_d              = ST_ERROR;
                        timeout_err_d        = 1'b1;
                        fail_stage_d         = idx_q;
                        stage_reset_d[idx_q] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (delay_end) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!(&stage_ready)) begin
                        state_d                 = ST_ERROR;
                        all_ready_d             = 1'b0;
                        timeout_err_d           = 1'b1;
                        fail_stage_d            = drop_idx;
                        stage_reset_d[drop_idx] = 1'b1;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge in_reset) begin
        if (in_reset) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            stage_reset_q <= '1;
            all_ready_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            fail_stage_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stage_reset_q <= stage_reset_d;
            all_ready_q   <= all_ready_d;
            timeout_err_q <= timeout_err_d;
            fail_stage_q  <= fail_stage_d;
        end
    end

    assign stage_reset = stage_reset_q;
    assign all_ready   = all_ready_q;
    assign timeout_err = timeout_err_q;
    assign fail_stage  = fail_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: event-time reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reset_sequencer;

    localparam int unsigned N   = 3;
    localparam int unsigned SD  = 4;
    localparam int unsigned TO  = 8;
    localparam int unsigned FSW = 2;

    logic           clk;
    logic           in_reset;
    logic           sw_reset_req;
    logic [N-1:0]   stage_ready;
    logic [N-1:0]   stage_reset;
    logic           all_ready;
    logic           timeout_err;
    logic [FSW-1:0] fail_stage;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_en = 0;

    reset_sequencer #(
        .NUM_STAGES (N),
        .STAGE_DELAY(SD),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .in_reset    (in_reset),
        .sw_reset_req(sw_reset_req),
        .stage_ready (stage_ready),
        .stage_reset (stage_reset),
        .all_ready   (all_ready),
        .timeout_err (timeout_err),
        .fail_stage  (fail_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: timeline of release edges counted from sequence start.
    int unsigned  m_edge, m_next_rel, m_wait_start, m_k;
    bit           m_waiting, m_done, m_err;
    logic [N-1:0] m_sr;
    logic         m_ar, m_te;
    logic [FSW-1:0] m_fs;

    task automatic model_clear();
        m_edge     = 0;
        m_next_rel = SD + 1;
        m_wait_start = 0;
        m_k        = 0;
        m_waiting  = 0;
        m_done     = 0;
        m_err      = 0;
        m_sr       = '1;
        m_ar       = 1'b0;
        m_te       = 1'b0;
        m_fs       = '0;
    endtask

    always @(posedge clk or posedge in_reset) begin
        if (in_reset || sw_reset_req) begin
            model_clear();
        end else begin
            m_edge++;
            if (m_err) begin
                m_edge = m_edge;
            end else if (m_done) begin
                if (stage_ready != '1) begin
                    bit found = 0;
                    for (int i = 0; i < int'(N); i++) begin
                        if (!found && !stage_ready[i]) begin
                            found = 1;
                            m_fs  = FSW'(i);
                            m_sr[i] = 1'b1;
                        end
                    end
                    m_err = 1;
                    m_ar  = 1'b0;
                    m_te  = 1'b1;
                end
            end else if (m_waiting) begin
                if (stage_ready[m_k]) begin
                    if (m_k == N - 1) begin
                        m_done = 1;
                        m_ar   = 1'b1;
                    end else begin
                        m_k++;
                        m_waiting  = 0;
                        m_next_rel = m_edge + SD + 1;
                    end
                end else if (m_edge == m_wait_start + TO) begin
                    m_err     = 1;
                    m_te      = 1'b1;
                    m_fs      = FSW'(m_k);
                    m_sr[m_k] = 1'b1;
                end
            end else if (m_edge == m_next_rel) begin
                m_sr[m_k]    = 1'b0;
                m_waiting    = 1;
                m_wait_start = m_edge;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model stage_reset", 32'(stage_reset), 32'(m_sr));
            check("model all_ready",   32'(all_ready),   32'(m_ar));
            check("model timeout_err", 32'(timeout_err), 32'(m_te));
            check("model fail_stage",  32'(fail_stage),  32'(m_fs));
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sw_pulse();
        sw_reset_req = 1'b1;
        adv(1);
        sw_reset_req = 1'b0;
    endtask

    initial begin
        in_reset     = 1'b1;
        sw_reset_req = 1'b0;
        stage_ready  = 3'b111;
        adv(2);
        chk_en = 1;
        check("reset stage_reset", 32'(stage_reset), 32'h7);
        check("reset all_ready",   32'(all_ready),   32'h0);
        check("reset timeout_err", 32'(timeout_err), 32'h0);
        check("reset fail_stage",  32'(fail_stage),  32'h0);

        // Full sequence with every domain ready.
        in_reset = 1'b0;
        adv(4);  check("s1 e4 stage_reset",  32'(stage_reset), 32'h7);
        adv(1);  check("s1 e5 stage_reset",  32'(stage_reset), 32'h6);
        adv(5);  check("s1 e10 stage_reset", 32'(stage_reset), 32'h6);
        adv(1);  check("s1 e11 stage_reset", 32'(stage_reset), 32'h4);
        adv(6);  check("s1 e17 stage_reset", 32'(stage_reset), 32'h0);
                 check("s1 e17 all_ready",   32'(all_ready),   32'h0);
        adv(1);  check("s1 e18 all_ready",   32'(all_ready),   32'h1);

        // Ready drop while done.
        adv(2);  check("s3 done all_ready",  32'(all_ready),   32'h1);
        stage_ready = 3'b101;
        adv(1);  check("s3 drop all_ready",  32'(all_ready),   32'h0);
                 check("s3 drop timeout_err",32'(timeout_err), 32'h1);
                 check("s3 drop fail_stage", 32'(fail_stage),  32'h1);
                 check("s3 drop stage_reset",32'(stage_reset), 32'h2);
        stage_ready = 3'b111;
        adv(3);  check("s3 frozen stage_reset", 32'(stage_reset), 32'h2);

        // Software re-sequence from error.
        sw_pulse();
        check("s4 sw stage_reset", 32'(stage_reset), 32'h7);
        check("s4 sw timeout_err", 32'(timeout_err), 32'h0);
        check("s4 sw fail_stage",  32'(fail_stage),  32'h0);
        adv(5);  check("s4 e5 stage_reset", 32'(stage_reset), 32'h6);
        adv(13); check("s4 e18 all_ready",  32'(all_ready),   32'h1);

        // Stage 1 never ready: timeout at release edge 11 + 8.
        stage_ready = 3'b101;
        sw_pulse();
        adv(18); check("s2 e18 timeout_err", 32'(timeout_err), 32'h0);
                 check("s2 e18 stage_reset", 32'(stage_reset), 32'h4);
        adv(1);  check("s2 e19 timeout_err", 32'(timeout_err), 32'h1);
                 check("s2 e19 fail_stage",  32'(fail_stage),  32'h1);
                 check("s2 e19 stage_reset", 32'(stage_reset), 32'h6);
        stage_ready = 3'b111;
        adv(20); check("s2 frozen stage_reset", 32'(stage_reset), 32'h6);
                 check("s2 frozen timeout_err", 32'(timeout_err), 32'h1);
                 check("s2 frozen all_ready",   32'(all_ready),   32'h0);

        // sw_reset_req coincident with stage 0 acceptance.
        sw_pulse();
        adv(5);  check("s6 e5 stage_reset", 32'(stage_reset), 32'h6);
        sw_pulse();
        check("s6 sw stage_reset", 32'(stage_reset), 32'h7);
        adv(5);  check("s6 e5b stage_reset",  32'(stage_reset), 32'h6);
        adv(6);  check("s6 e11b stage_reset", 32'(stage_reset), 32'h4);

        // Ready arriving on the last allowed WAIT cycle is accepted.
        stage_ready = 3'b000;
        sw_pulse();
        adv(12); check("s7 e12 stage_reset", 32'(stage_reset), 32'h6);
        stage_ready = 3'b001;
        adv(1);  check("s7 e13 timeout_err", 32'(timeout_err), 32'h0);
        adv(5);  check("s7 e18 stage_reset", 32'(stage_reset), 32'h4);
        adv(7);  check("s7 e25 timeout_err", 32'(timeout_err), 32'h0);
        adv(1);  check("s7 e26 timeout_err", 32'(timeout_err), 32'h1);
                 check("s7 e26 stage_reset", 32'(stage_reset), 32'h6);

        // Asynchronous reset during stage 2 wait.
        stage_ready = 3'b011;
        sw_pulse();
        adv(19); check("s5 e19 stage_reset", 32'(stage_reset), 32'h0);
        @(posedge clk);
        #2 in_reset = 1'b1;
        #1;
        check("s5 async stage_reset", 32'(stage_reset), 32'h7);
        check("s5 async all_ready",   32'(all_ready),   32'h0);
        @(negedge clk);
        in_reset    = 1'b0;
        stage_ready = 3'b111;
        adv(5);  check("s5 e5 stage_reset", 32'(stage_reset), 32'h6);
        adv(13); check("s5 e18 all_ready",  32'(all_ready),   32'h1);

        adv(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
